// File: rtl/data_memory_banked.sv
// Byte-addressed data memory: four 8-bit lane banks, valid/ready request, one-cycle response pulse.
// Define DATAMEMORY_MISALIGN_SPLIT_EN to split word-crossing accesses; otherwise they fault.
module data_memory_banked #(
    parameter int unsigned DEPTH_WORD = 4096,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_width,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORD);
    localparam logic [ADDR_WIDTH:0] MemBytes = (ADDR_WIDTH+1)'(DEPTH_WORD * 4);

    typedef enum logic [1:0] {StIdle, StAcc1, StAcc2} state_e;

    state_e          state_q;
    logic            req_ready_q, resp_valid_q, resp_error_q;
    logic            write_q, unsigned_q, cross_q, err_q;
    logic [1:0]      width_q, off_q;
    logic [IdxW-1:0] widx_q;
    logic [31:0]     wdata_q, lo_q;
    logic [7:0]      lane_mask_q;

    // Accept-time decode: byte count, crossing, lane mask and fault.
    logic [2:0]            nbytes_m1;
    logic [3:0]            nmask;
    logic [ADDR_WIDTH:0]   last_byte;
    logic                  cross_c, err_c;
    logic [7:0]            mask_c;

    always_comb begin
        nbytes_m1 = 3'd3;
        nmask     = 4'b1111;
        case (req_width)
            2'd0:    begin nbytes_m1 = 3'd0; nmask = 4'b0001; end
            2'd1:    begin nbytes_m1 = 3'd1; nmask = 4'b0011; end
            default: begin nbytes_m1 = 3'd3; nmask = 4'b1111; end
        endcase
        // One extra bit so the top-of-range check cannot wrap.
        last_byte = {1'b0, req_addr} + (ADDR_WIDTH+1)'(nbytes_m1);
        cross_c   = ({1'b0, req_addr[1:0]} + nbytes_m1) > 3'd3;
        mask_c    = {4'b0000, nmask} << req_addr[1:0];
        err_c     = (req_width == 2'd3) || (last_byte >= MemBytes);
`ifndef DATAMEMORY_MISALIGN_SPLIT_EN
        err_c     = err_c || cross_c;
`endif
    end

    // Bank access: ACC1 touches word w (lanes [3:0]), ACC2 word w+1 (lanes [7:4]).
    logic            acc_en;
    logic [IdxW-1:0] acc_word;
    logic [3:0]      acc_lanes;
    logic [31:0]     bank_rd;

    always_comb begin
        acc_en    = (state_q != StIdle) && !err_q;
        acc_word  = (state_q == StAcc2) ? widx_q + IdxW'(1) : widx_q;
        acc_lanes = (state_q == StAcc2) ? lane_mask_q[7:4] : lane_mask_q[3:0];
    end

    for (genvar l = 0; l < 4; l++) begin : g_bank
        logic [7:0] mem [DEPTH_WORD];
        logic [7:0] rd_q;
        logic [1:0] src;

        assign src = 2'(l) - off_q;
        assign bank_rd[8*l +: 8] = rd_q;

        always_ff @(posedge clk) begin
            if (acc_en) begin
                if (write_q) begin
                    if (acc_lanes[l]) mem[acc_word] <= wdata_q[{src, 3'b000} +: 8];
                end else begin
                    rd_q <= mem[acc_word];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            cross_q      <= 1'b0;
            err_q        <= 1'b0;
            width_q      <= 2'd0;
            off_q        <= 2'd0;
            widx_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            lane_mask_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        write_q     <= req_write;
                        unsigned_q  <= req_unsigned;
                        width_q     <= req_width;
                        off_q       <= req_addr[1:0];
                        widx_q      <= req_addr[IdxW+1:2];
                        wdata_q     <= req_wdata;
                        lane_mask_q <= mask_c;
                        cross_q     <= cross_c;
                        err_q       <= err_c;
                        state_q     <= StAcc1;
                    end
                end
                StAcc1: begin
                    if (cross_q && !err_q) begin
                        state_q <= StAcc2;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_error_q <= err_q;
                        req_ready_q  <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                StAcc2: begin
                    lo_q         <= bank_rd;
                    resp_valid_q <= 1'b1;
                    req_ready_q  <= 1'b1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Load assembly: byte k comes from lane off+k; lanes past 3 live in the second word.
    logic [31:0] lo_sel, raw, ext;
    logic [2:0]  idx;

    always_comb begin
        lo_sel = cross_q ? lo_q : bank_rd;
        raw    = '0;
        idx    = '0;
        for (int k = 0; k < 4; k++) begin
            idx = {1'b0, off_q} + 3'(k);
            raw[8*k +: 8] = idx[2] ? bank_rd[{idx[1:0], 3'b000} +: 8]
                                   : lo_sel[{idx[1:0], 3'b000} +: 8];
        end
        case (width_q)
            2'd0:    ext = {{24{~unsigned_q & raw[7]}}, raw[7:0]};
            2'd1:    ext = {{16{~unsigned_q & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
        resp_rdata = (resp_valid_q && !resp_error_q && !write_q) ? ext : 32'd0;
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;

endmodule
